// File: rtl/cp0_exc.sv
// cp0_exc: MIPS-style CP0 exception/interrupt register block.
// Holds BadVAddr, Count, Compare, Status, Cause and EPC; computes the pending
// interrupt request and the pipeline redirect target for exceptions and ERET.
// Optional feature macro: CP0_TIMER_INT_EN compiles in the Count/Compare
// timer interrupt (Cause.TI and IP[7]); without it TI reads 0.
module cp0_exc #(
    parameter int          HW_INT   = 6,
    parameter logic [31:0] EXC_BASE = 32'h8000_0180,
    parameter logic [31:0] BEV_BASE = 32'hBFC0_0380
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [4:0]        waddr,
    input  logic [31:0]       wdata,
    input  logic [4:0]        raddr,
    output logic [31:0]       rdata,
    input  logic [HW_INT-1:0] hw_int,
    input  logic              exc_req,
    input  logic [4:0]        exc_code,
    input  logic [31:0]       exc_pc,
    input  logic              exc_bd,
    input  logic [31:0]       exc_badva,
    input  logic              exc_badva_vld,
    input  logic              eret,
    output logic              int_req,
    output logic [31:0]       flush_pc,
    output logic              status_exl
);

    localparam logic [4:0] REG_BADVA   = 5'd8;
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    logic [31:0]       badva_reg;
    logic [31:0]       count_reg;
    logic [31:0]       compare_reg;
    logic [31:0]       epc_reg;
    logic              cu0_reg;
    logic              bev_reg;
    logic [7:0]        im_reg;
    logic              exl_reg;
    logic              ie_reg;
    logic              bd_reg;
    logic [1:0]        ip_sw_reg;
    logic [4:0]        exccode_reg;
    logic [HW_INT-1:0] hw_reg;

    logic [5:0]        hw_ext;
    logic              ti_bit;
    logic [7:0]        ip;
    logic              mtc0;

    // An MTC0 only takes effect when no exception or ERET commits in the same cycle.
    assign mtc0 = wen & ~exc_req & ~eret;

    // Spread the registered hardware lines over IP[7:2]; absent lines read 0.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_ip
            if (gi < HW_INT) begin : g_used
                assign hw_ext[gi] = hw_reg[gi];
            end else begin : g_unused
                assign hw_ext[gi] = 1'b0;
            end
        end
    endgenerate

`ifdef CP0_TIMER_INT_EN
    logic ti_reg;

    // Sticky timer flag: set on a non-zero Compare match, cleared by writing Compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ti_reg <= 1'b0;
        end else if (mtc0 && waddr == REG_COMPARE) begin
            ti_reg <= 1'b0;
        end else if (count_reg == compare_reg && compare_reg != 32'd0) begin
            ti_reg <= 1'b1;
        end
    end

    assign ti_bit = ti_reg;
`else
    assign ti_bit = 1'b0;
`endif

    assign ip = {hw_ext[5] | ti_bit, hw_ext[4:0], ip_sw_reg};

    // Free-running Count; a committed MTC0 to Count overrides the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= 32'd0;
        end else if (mtc0 && waddr == REG_COUNT) begin
            count_reg <= wdata;
        end else begin
            count_reg <= count_reg + 32'd1;
        end
    end

    // Sample the external interrupt lines into Cause.IP every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hw_reg <= '0;
        end else begin
            hw_reg <= hw_int;
        end
    end

    // Exception commit, ERET and MTC0 updates, in that priority order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            badva_reg   <= 32'd0;
            compare_reg <= 32'd0;
            epc_reg     <= 32'd0;
            cu0_reg     <= 1'b0;
            bev_reg     <= 1'b1;
            im_reg      <= 8'd0;
            exl_reg     <= 1'b0;
            ie_reg      <= 1'b0;
            bd_reg      <= 1'b0;
            ip_sw_reg   <= 2'd0;
            exccode_reg <= 5'd0;
        end else if (exc_req) begin
            exl_reg     <= 1'b1;
            exccode_reg <= exc_code;
            // Nested exceptions keep the original return point.
            if (!exl_reg) begin
                epc_reg <= exc_bd ? exc_pc - 32'd4 : exc_pc;
                bd_reg  <= exc_bd;
            end
            if (exc_badva_vld) begin
                badva_reg <= exc_badva;
            end
        end else if (eret) begin
            exl_reg <= 1'b0;
        end else if (wen) begin
            case (waddr)
                REG_COMPARE: compare_reg <= wdata;
                REG_STATUS: begin
                    cu0_reg <= wdata[28];
                    bev_reg <= wdata[22];
                    im_reg  <= wdata[15:8];
                    exl_reg <= wdata[1];
                    ie_reg  <= wdata[0];
                end
                REG_CAUSE:   ip_sw_reg <= wdata[9:8];
                REG_EPC:     epc_reg   <= wdata;
                default:     ;
            endcase
        end
    end

    // Combinational register read port.
    always_comb begin
        rdata = 32'd0;
        case (raddr)
            REG_BADVA:   rdata = badva_reg;
            REG_COUNT:   rdata = count_reg;
            REG_COMPARE: rdata = compare_reg;
            REG_STATUS:  rdata = {3'b0, cu0_reg, 5'b0, bev_reg, 6'b0, im_reg, 6'b0, exl_reg, ie_reg};
            REG_CAUSE:   rdata = {bd_reg, ti_bit, 14'b0, ip, 1'b0, exccode_reg, 2'b0};
            REG_EPC:     rdata = epc_reg;
            default:     rdata = 32'd0;
        endcase
    end

    // Redirect target: vector on exception, EPC on ERET; nothing while held in reset.
    always_comb begin
        flush_pc = 32'd0;
        if (!rst) begin
            if (exc_req) begin
                flush_pc = bev_reg ? BEV_BASE : EXC_BASE;
            end else if (eret) begin
                flush_pc = epc_reg;
            end
        end
    end

    assign int_req    = ie_reg & ~exl_reg & (|(ip & im_reg));
    assign status_exl = exl_reg;

endmodule

// File: tb/tb_cp0_exc.sv
// tb_cp0_exc: directed and randomized checks of cp0_exc against a word-level
// behavioural model of the CP0 registers.
module tb_cp0_exc;

    localparam logic [31:0] EXC_BASE = 32'h8000_0180;
    localparam logic [31:0] BEV_BASE = 32'hBFC0_0380;
    localparam logic [31:0] SMASK    = 32'h1040_FF03;
    localparam logic [31:0] CMASK    = 32'h0000_0300;
`ifdef CP0_TIMER_INT_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wen = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  raddr = '0;
    logic [31:0] rdata;
    logic [5:0]  hw_int = '0;
    logic        exc_req = 1'b0;
    logic [4:0]  exc_code = '0;
    logic [31:0] exc_pc = '0;
    logic        exc_bd = 1'b0;
    logic [31:0] exc_badva = '0;
    logic        exc_badva_vld = 1'b0;
    logic        eret = 1'b0;
    logic        int_req;
    logic [31:0] flush_pc;
    logic        status_exl;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: Cause holds only BD, soft IP and ExcCode; hw IP and TI are added on read.
    logic [31:0] m_badva, m_count, m_compare, m_status, m_cause, m_epc;
    logic [5:0]  m_hw;
    bit          m_ti;

    cp0_exc dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .hw_int(hw_int), .exc_req(exc_req),
        .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
        .exc_badva(exc_badva), .exc_badva_vld(exc_badva_vld), .eret(eret),
        .int_req(int_req), .flush_pc(flush_pc), .status_exl(status_exl)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_cause_word();
        return m_cause | (32'(m_hw) << 10) | (m_ti ? 32'h4000_8000 : 32'h0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badva;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause_word();
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_int();
        logic [7:0] ipv;
        ipv = m_cause_word()[15:8];
        return m_status[0] & ~m_status[1] & (|(ipv & m_status[15:8]));
    endfunction

    function automatic logic [31:0] m_flush();
        if (exc_req) return m_status[22] ? BEV_BASE : EXC_BASE;
        if (eret) return m_epc;
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_badva = 0; m_count = 0; m_compare = 0; m_status = 32'h0040_0000;
        m_cause = 0; m_epc = 0; m_hw = 0; m_ti = 0;
    endtask

    // One clock edge of the register file, applied to the model.
    task automatic model_step();
        logic [31:0] cnt_n;
        bit ti_n;
        cnt_n = m_count + 32'd1;
        ti_n = m_ti;
        if (TIMER && m_count == m_compare && m_compare != 0) ti_n = 1;
        m_hw = hw_int;
        if (exc_req) begin
            if (!m_status[1]) begin
                m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
                m_cause[31] = exc_bd;
            end
            m_status[1] = 1'b1;
            m_cause[6:2] = exc_code;
            if (exc_badva_vld) m_badva = exc_badva;
        end else if (eret) begin
            m_status[1] = 1'b0;
        end else if (wen) begin
            case (waddr)
                5'd9:  cnt_n = wdata;
                5'd11: begin m_compare = wdata; ti_n = 0; end
                5'd12: m_status = (m_status & ~SMASK) | (wdata & SMASK);
                5'd13: m_cause = (m_cause & ~CMASK) | (wdata & CMASK);
                5'd14: m_epc = wdata;
                default: ;
            endcase
        end
        m_count = cnt_n;
        m_ti = ti_n;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        raddr = a;
        #1;
        v = rdata;
    endtask

    task automatic check_regs();
        logic [4:0] tab [9];
        logic [31:0] v;
        tab = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd10, 5'd31};
        foreach (tab[k]) begin
            rd(tab[k], v);
            chk($sformatf("reg%0d", tab[k]), v, m_read(tab[k]));
        end
        chk("int_req", {31'b0, int_req}, {31'b0, m_int()});
        chk("status_exl", {31'b0, status_exl}, {31'b0, m_status[1]});
    endtask

    // Check redirect, clock once, update model, check state, drop one-shot inputs.
    task automatic tick();
        #1;
        chk("flush_pc", flush_pc, m_flush());
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_regs();
        wen = 0; exc_req = 0; eret = 0; exc_badva_vld = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        wen = 1; waddr = a; wdata = d;
        tick();
    endtask

    task automatic do_reset();
        rst = 1;
        model_reset();
        exc_req = 1; wen = 1; waddr = 5'd12; wdata = 32'h0; eret = 0;
        check_regs();
        @(posedge clk);
        @(negedge clk);
        check_regs();
        rst = 0;
        wen = 0; exc_req = 0; eret = 0; exc_badva_vld = 0;
    endtask

    initial begin
        logic [31:0] v;
        logic [4:0]  atab [7];
        atab = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};

        // Reset state.
        model_reset();
        @(negedge clk);
        check_regs();
        rd(5'd12, v); chk("rst_status", v, 32'h0040_0000);
        rd(5'd9, v);  chk("rst_count", v, 32'h0);
        rst = 0;

        // Exception from a delay slot, then a nested one.
        exc_req = 1; exc_pc = 32'h8000_1000; exc_bd = 1; exc_code = 5'd4;
        exc_badva = 32'h1234_5677; exc_badva_vld = 1;
        #1; chk("vec_bev", flush_pc, BEV_BASE);
        tick();
        rd(5'd14, v); chk("epc_bd", v, 32'h8000_0FFC);
        rd(5'd13, v); chk("cause_bd_code", v & 32'h8000_007C, 32'h8000_0010);
        rd(5'd8, v);  chk("badva", v, 32'h1234_5677);
        exc_req = 1; exc_pc = 32'h8000_2000; exc_bd = 0; exc_code = 5'd5;
        tick();
        rd(5'd14, v); chk("epc_nested", v, 32'h8000_0FFC);
        eret = 1;
        tick();
        chk("eret_exl", {31'b0, status_exl}, 32'h0);

        // Interrupt masking.
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001;
        tick();
        chk("int_on", {31'b0, int_req}, 32'h1);
        mtc0(5'd12, 32'h0000_0403);
        chk("int_exl", {31'b0, int_req}, 32'h0);
        hw_int = 6'b0;
        mtc0(5'd12, 32'h0000_0000);

        // Timer interrupt.
        mtc0(5'd11, 32'd20);
        mtc0(5'd9, 32'd10);
        repeat (10) tick();
        rd(5'd13, v); chk("ti_early", {31'b0, v[30]}, 32'h0);
        tick();
        rd(5'd13, v);
        chk("ti_set", {31'b0, v[30]}, {31'b0, TIMER});
        chk("ip7_set", {31'b0, v[15]}, {31'b0, TIMER});
        mtc0(5'd11, 32'd100);
        rd(5'd13, v); chk("ti_clr", {31'b0, v[30]}, 32'h0);

        // Same-cycle exception, ERET and MTC0; Count wrap.
        exc_req = 1; eret = 1; wen = 1; waddr = 5'd14; wdata = 32'hDEAD_BEEF;
        exc_pc = 32'h8000_3000; exc_bd = 0; exc_code = 5'd8;
        #1; chk("vec_exc", flush_pc, EXC_BASE);
        tick();
        chk("prio_exl", {31'b0, status_exl}, 32'h1);
        rd(5'd14, v); chk("prio_epc", v, 32'h8000_3000);
        eret = 1;
        #1; chk("eret_pc", flush_pc, 32'h8000_3000);
        tick();
        mtc0(5'd9, 32'hFFFF_FFFF);
        rd(5'd9, v); chk("count_max", v, 32'hFFFF_FFFF);
        tick();
        rd(5'd9, v); chk("count_wrap", v, 32'h0);

        // Randomized traffic against the model, with one reset in the middle.
        for (int i = 0; i < 400; i++) begin
            int r;
            if (i == 200) do_reset();
            hw_int = 6'($urandom);
            wen = ($urandom_range(0, 2) == 0);
            waddr = ($urandom_range(0, 7) == 7) ? 5'($urandom) : atab[$urandom_range(0, 6)];
            wdata = $urandom;
            if (waddr == 5'd11 && $urandom_range(0, 1) == 1) wdata = m_count + $urandom_range(2, 6);
            r = $urandom_range(0, 9);
            exc_req = (r == 0);
            eret = (r == 1) || (r == 2 && exc_req);
            exc_code = 5'($urandom);
            exc_pc = $urandom;
            exc_bd = 1'($urandom);
            exc_badva = $urandom;
            exc_badva_vld = 1'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cp0_exc.md
CP0_EXC -- requirements
Module: cp0_exc

Interface
REQ-001 SHALL have parameter HW_INT, default 6, meaning number of hardware interrupt lines (1..6).
REQ-002 SHALL have parameter EXC_BASE, default 32'h8000_0180, meaning exception vector when Status.BEV=0.
REQ-003 SHALL have parameter BEV_BASE, default 32'hBFC0_0380, meaning exception vector when Status.BEV=1.
REQ-004 SHALL have ports, in order: clk in 1 clock; rst in 1 reset (asynchronous, active-high).
REQ-005 SHALL have ports wen in 1 MTC0 strobe; waddr in 5 write register; wdata in 32 write data; raddr in 5 read register; rdata out 32 read data.
REQ-006 SHALL have ports hw_int in HW_INT external interrupts; exc_req in 1 exception commit; exc_code in 5 ExcCode; exc_pc in 32 faulting PC; exc_bd in 1 faulting instruction in delay slot.
REQ-007 SHALL have ports exc_badva in 32 bad address; exc_badva_vld in 1 load BadVAddr; eret in 1 ERET commit.
REQ-008 SHALL have ports int_req out 1 interrupt pending to pipeline; flush_pc out 32 redirect target; status_exl out 1 Status.EXL.

Function
REQ-009 SHALL implement BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); other raddr read 0, other waddr writes ignored.
REQ-010 SHALL return rdata combinationally from current register state; a write becomes visible the following cycle.
REQ-011 SHALL provide writable fields: Status CU0[28], BEV[22], IM[15:8], EXL[1], IE[0]; Cause IP[9:8] only; EPC all bits; Compare all bits; Count all bits; BadVAddr read-only via MTC0.
REQ-012 SHALL register Cause.IP[2+i] <= hw_int[i] every cycle for i < HW_INT; unused IP[7:2+HW_INT] read 0 (except IP[7] under REQ-024).
REQ-013 SHALL drive int_req = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM), combinational.
REQ-014 SHALL, on exc_req, set EXL=1, ExcCode=exc_code; if EXL was 0, load EPC = exc_bd ? exc_pc-4 : exc_pc and BD = exc_bd; if EXL was 1, hold EPC and BD.
REQ-015 SHALL load BadVAddr = exc_badva on exc_req & exc_badva_vld; otherwise hold.
REQ-016 SHALL drive flush_pc = BEV ? BEV_BASE : EXC_BASE when exc_req, EPC when eret, else 0, combinational.
REQ-017 SHALL, on eret, clear EXL the next cycle.
REQ-018 SHALL prioritise same-cycle events: exc_req over eret over wen; the losing eret and wen are discarded completely.
REQ-019 SHALL increment Count by 1 every cycle, wrapping 32'hFFFF_FFFF to 0; an MTC0 to Count takes precedence over the increment.

Reset
REQ-020 SHALL, on rst asserted, asynchronously clear all registers except Status.BEV=1; rdata, int_req, flush_pc follow from cleared state (int_req=0).
REQ-021 SHALL discard any exc_req, eret or wen sampled while rst is high.
REQ-022 SHALL resume Count incrementing on the first clk edge after rst deasserts, from 0.

Configuration
REQ-023 SHALL use macro CP0_TIMER_INT_EN to compile the timer interrupt in or out.
REQ-024 With CP0_TIMER_INT_EN defined: when Count == Compare and Compare != 0, Cause.TI[30] and IP[7] SHALL set sticky the next cycle, OR-ed with hw_int[5] if present; an MTC0 to Compare SHALL clear TI.
REQ-025 Without CP0_TIMER_INT_EN: Cause.TI SHALL read 0, Compare SHALL remain readable/writable, and IP[7] SHALL reflect hw_int[5] only.

Verification
REQ-026 Reset, then read Status -> 32'h0040_0000; Cause, EPC, Count read 0; int_req=0.
REQ-027 exc_req with exc_pc=32'h8000_1000, exc_bd=1, code=5'd4, badva=32'h1234_5677 vld -> EPC=32'h8000_0FFC, BD=1, ExcCode=4, BadVAddr=32'h1234_5677, flush_pc=BEV_BASE; second exc_req with pc=32'h8000_2000 -> EPC unchanged.
REQ-028 Write Status=32'h0000_0401 (IM2, IE), drive hw_int[0]=1 -> int_req=1 one cycle later; set EXL -> int_req=0.
REQ-029 With macro: Compare=20, Count=10 -> TI=1, IP[7]=1 after 11 cycles; write Compare=100 -> TI=0. Without macro: TI stays 0.
REQ-030 Same-cycle exc_req, eret, wen to EPC -> EXL=1, EPC=exception value, flush_pc=vector; Count write 32'hFFFF_FFFF -> reads 0 one cycle later.
